// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter
//   Shares one byte-wide memory port between instruction fetch (I) and
//   load/store (D). A granted request is broken into 1, 2 or 4 sequential
//   byte beats, little-endian, and a single-cycle response is returned to
//   the port that owns the transfer. Contention is resolved round-robin.
//
// Ports
//   clk, reset                 clock (posedge) / async active-high reset
//   i_req_valid/ready/addr     fetch request (always a 32-bit read)
//   i_rsp_valid/data           fetch response pulse and word
//   d_req_valid/ready/addr     load/store request
//   d_req_we/size/wdata        store flag, size (0=B,1=H,2/3=W), store data
//   d_rsp_valid/data           load data (zero-extended) / store completion
//   mem_addr/re/we/wdata       byte memory command
//   mem_rdata                  byte read data, one cycle after mem_re
module rv_mem_arbiter #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req_valid,
    output logic          i_req_ready,
    input  logic [AW-1:0] i_req_addr,
    output logic          i_rsp_valid,
    output logic [31:0]   i_rsp_data,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic [AW-1:0] d_req_addr,
    input  logic          d_req_we,
    input  logic [1:0]    d_req_size,
    input  logic [31:0]   d_req_wdata,
    output logic          d_rsp_valid,
    output logic [31:0]   d_rsp_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t        state, state_nxt;
    logic [1:0]    k_q;          // current beat index
    logic [1:0]    last_k_q;     // index of the final beat (N-1)
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic          owner_q;
    logic          last_grant_q;
    logic [31:0]   wdata_q;
    logic [31:0]   acc_q;        // read bytes gathered so far
    logic [31:0]   i_hold_q;
    logic [31:0]   d_hold_q;

    logic [31:0]   wdata_sh;
    logic [31:0]   rdata_ext;
    logic [31:0]   rsp_word;
    logic [1:0]    last_k_d;

    // Byte count of a load/store: byte, half, or word for both size 2 and 3.
    always_comb begin
        case (d_req_size)
            2'd0:    last_k_d = 2'd0;
            2'd1:    last_k_d = 2'd1;
            default: last_k_d = 2'd3;
        endcase
    end

    // Next state, readys, memory strobes and response pulses.
    always_comb begin
        state_nxt   = state;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_rsp_valid = 1'b0;
        d_rsp_valid = 1'b0;
        wdata_sh    = wdata_q >> {k_q, 3'b000};
        rdata_ext   = {24'd0, mem_rdata} << {last_k_q, 3'b000};
        // The final read byte arrives during DONE, so it is merged here
        // instead of waiting another cycle for it to land in acc_q.
        rsp_word    = we_q ? acc_q : (acc_q | rdata_ext);

        case (state)
            IDLE: begin
                // Readys stay low while reset is held so nothing looks
                // accepted during reset. On contention the port that did
                // not win last time is served.
                if (!reset) begin
                    i_req_ready = i_req_valid & (~d_req_valid | (last_grant_q == OWN_D));
                    d_req_ready = d_req_valid & (~i_req_valid | (last_grant_q == OWN_I));
                end
                if (i_req_ready || d_req_ready) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                mem_addr  = addr_q + AW'(k_q);
                mem_re    = ~we_q;
                mem_we    = we_q;
                mem_wdata = wdata_sh[7:0];
                if (k_q == last_k_q) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                i_rsp_valid = (owner_q == OWN_I);
                d_rsp_valid = (owner_q == OWN_D);
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response data is live during DONE and otherwise shows the held value.
    assign i_rsp_data = (state == DONE && owner_q == OWN_I) ? rsp_word : i_hold_q;
    assign d_rsp_data = (state == DONE && owner_q == OWN_D) ? rsp_word : d_hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q          <= '0;
            last_k_q     <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            wdata_q      <= '0;
            acc_q        <= '0;
            i_hold_q     <= '0;
            d_hold_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req_ready) begin
                        addr_q       <= d_req_addr;
                        we_q         <= d_req_we;
                        wdata_q      <= d_req_wdata;
                        last_k_q     <= last_k_d;
                        owner_q      <= OWN_D;
                        last_grant_q <= OWN_D;
                        acc_q        <= '0;
                        k_q          <= '0;
                    end else if (i_req_ready) begin
                        addr_q       <= i_req_addr;
                        we_q         <= 1'b0;
                        wdata_q      <= '0;
                        last_k_q     <= 2'd3;
                        owner_q      <= OWN_I;
                        last_grant_q <= OWN_I;
                        acc_q        <= '0;
                        k_q          <= '0;
                    end
                end
                XFER: begin
                    k_q <= k_q + 2'd1;
                    // mem_rdata currently carries the byte requested by
                    // the previous beat.
                    if (!we_q && k_q != 2'd0) begin
                        acc_q <= acc_q | ({24'd0, mem_rdata} << {k_q - 2'd1, 3'b000});
                    end
                end
                DONE: begin
                    if (owner_q == OWN_I) begin
                        i_hold_q <= rsp_word;
                    end else begin
                        d_hold_q <= rsp_word;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Testbench for rv_mem_arbiter: byte memory model, directed vectors,
// contention/reset sequences and randomized traffic against a byte-level
// reference model.
module tb_rv_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        i_req_ready;
    logic [31:0] i_req_addr = '0;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        d_req_valid = 1'b0;
    logic        d_req_ready;
    logic [31:0] d_req_addr = '0;
    logic        d_req_we = 1'b0;
    logic [1:0]  d_req_size = '0;
    logic [31:0] d_req_wdata = '0;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    rv_mem_arbiter #(.AW(32)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_size(d_req_size), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Byte memory, indexed by the low 12 address bits (all used addresses
    // are distinct in that window).
    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic        clr_mem = 1'b1;
    logic        pk_en = 1'b0;
    logic [11:0] pk_a = '0;
    logic [7:0]  pk_d = '0;

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        end else begin
            if (pk_en)  mem[pk_a] <= pk_d;
            if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
        end
        if (mem_re) mem_rdata <= mem[mem_addr[11:0]];
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        pk_a  = a[11:0];
        pk_d  = d;
        pk_en = 1'b1;
        @(negedge clk); #1;
        pk_en = 1'b0;
        ref_mem[a[11:0]] = d;
    endtask

    // Reference model: byte-by-byte little-endian access with address wrap.
    task automatic model_access(input bit is_d, input bit we, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] result);
        int n;
        logic [31:0] a;
        n = (!is_d) ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        result = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + i;
            if (we) ref_mem[a[11:0]] = wdata[8*i +: 8];
            else    result[8*i +: 8] = ref_mem[a[11:0]];
        end
    endtask

    // Issue one request (called just after a negedge) and check the whole
    // transaction: acceptance, beats, latency, data, hold and pulse width.
    task automatic do_req(input string tag, input bit is_d, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
        int n, lat, spur, waited;
        bit rdy;
        logic [31:0] got;
        logic [31:0] ba[$];
        logic        bw[$];
        logic [7:0]  bd[$];
        n = (!is_d) ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        lat = 0; spur = 0; waited = 0; got = '0;
        if (is_d) begin
            d_req_valid = 1'b1; d_req_addr = addr; d_req_we = we;
            d_req_size = size; d_req_wdata = wdata;
        end else begin
            i_req_valid = 1'b1; i_req_addr = addr;
        end
        #1;
        rdy = is_d ? d_req_ready : i_req_ready;
        while (!rdy && waited < 20) begin
            @(negedge clk); #1;
            waited++;
            rdy = is_d ? d_req_ready : i_req_ready;
        end
        chk({tag, ".accept"}, 32'(rdy), 32'd1);
        if (!rdy) begin
            i_req_valid = 1'b0; d_req_valid = 1'b0;
            return;
        end
        @(negedge clk); #1;
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (mem_re || mem_we) begin
                ba.push_back(mem_addr); bw.push_back(mem_we); bd.push_back(mem_wdata);
            end
            if (i_req_ready || d_req_ready) spur++;
            if (is_d ? i_rsp_valid : d_rsp_valid) spur++;
            if (is_d ? d_rsp_valid : i_rsp_valid) begin
                lat = c;
                got = is_d ? d_rsp_data : i_rsp_data;
                break;
            end
            @(negedge clk); #1;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(n + 1));
        chk({tag, ".data"}, got, exp);
        chk({tag, ".beats"}, 32'(ba.size()), 32'(n));
        chk({tag, ".spurious"}, 32'(spur), 32'd0);
        for (int k = 0; k < ba.size() && k < n; k++) begin
            chk($sformatf("%s.addr%0d", tag, k), ba[k], addr + k);
            chk($sformatf("%s.we%0d", tag, k), 32'(bw[k]), 32'(we));
            if (we) chk($sformatf("%s.wdata%0d", tag, k), 32'(bd[k]), (wdata >> (8*k)) & 32'hFF);
        end
        @(negedge clk); #1;
        chk({tag, ".hold"}, is_d ? d_rsp_data : i_rsp_data, got);
        chk({tag, ".pulse"}, 32'(is_d ? d_rsp_valid : i_rsp_valid), 32'd0);
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[11];

    initial begin
        int both_hi, quiet;
        int grants[$];
        logic [31:0] exp_r;
        bit rd, rw;
        logic [1:0] rs;
        logic [31:0] ra, rwd;

        vt[0]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0000, 32'h0,         32'h0010_0513};
        vt[1]  = '{1'b1, 1'b1, 2'd0, 32'd42,        32'hDEAD_BE07, 32'h0};
        vt[2]  = '{1'b1, 1'b0, 2'd0, 32'd42,        32'h0,         32'h0000_0007};
        vt[3]  = '{1'b1, 1'b0, 2'd0, 32'd43,        32'h0,         32'h0000_00AA};
        vt[4]  = '{1'b1, 1'b0, 2'd1, 32'h0000_07FF, 32'h0,         32'h0000_1234};
        vt[5]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'h0513_2211};
        vt[6]  = '{1'b1, 1'b1, 2'd3, 32'h0000_0100, 32'hCAFE_F00D, 32'h0};
        vt[7]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0101, 32'h0,         32'h5ACA_FEF0};
        vt[8]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0200, 32'h1234_5678, 32'h0};
        vt[9]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'h0000_5678};
        vt[10] = '{1'b1, 1'b0, 2'd1, 32'h0000_0102, 32'h0,         32'h0000_CAFE};

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        @(negedge clk); #1;
        clr_mem = 1'b0;
        poke(32'h0, 8'h13); poke(32'h1, 8'h05); poke(32'h2, 8'h10); poke(32'h3, 8'h00);
        poke(32'd43, 8'hAA);
        poke(32'h7FF, 8'h34); poke(32'h800, 8'h12);
        poke(32'hFFFF_FFFE, 8'h11); poke(32'hFFFF_FFFF, 8'h22);
        poke(32'h104, 8'h5A);
        poke(32'h300, 8'hAA); poke(32'h301, 8'hBB); poke(32'h302, 8'hCC); poke(32'h303, 8'hDD);

        // Reset values, with both requesters already pending.
        i_req_valid = 1'b1; i_req_addr = 32'h0;
        d_req_valid = 1'b1; d_req_addr = 32'h0; d_req_we = 1'b0; d_req_size = 2'd2;
        #1;
        chk("rst.i_ready", 32'(i_req_ready), 32'd0);
        chk("rst.d_ready", 32'(d_req_ready), 32'd0);
        chk("rst.strobes", {30'd0, mem_re, mem_we}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst.rsp_valid", {30'd0, i_rsp_valid, d_rsp_valid}, 32'd0);
        chk("rst.i_rsp_data", i_rsp_data, 32'd0);
        chk("rst.d_rsp_data", d_rsp_data, 32'd0);

        // Contention straight out of reset: D first, then alternating.
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        both_hi = 0;
        for (int c = 0; c < 80 && grants.size() < 4; c++) begin
            if (i_req_ready && d_req_ready) both_hi++;
            if (d_req_ready) grants.push_back(1);
            else if (i_req_ready) grants.push_back(0);
            @(negedge clk); #1;
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (7) begin
            @(negedge clk); #1;
            if (i_req_ready && d_req_ready) both_hi++;
        end
        chk("arb.count", 32'(grants.size()), 32'd4);
        for (int g = 0; g < 4; g++)
            chk($sformatf("arb.grant%0d", g), (g < grants.size()) ? 32'(grants[g]) : 32'd9,
                (g % 2 == 0) ? 32'd1 : 32'd0);
        chk("arb.both_ready", 32'(both_hi), 32'd0);
        chk("arb.i_data", i_rsp_data, 32'h0010_0513);
        chk("arb.d_data", d_rsp_data, 32'h0010_0513);

        // Reset pulse during beat 2 of a word store.
        d_req_valid = 1'b1; d_req_addr = 32'h300; d_req_we = 1'b1;
        d_req_size = 2'd2; d_req_wdata = 32'h4433_2211;
        #1;
        chk("rst_mid.accept", 32'(d_req_ready), 32'd1);
        @(negedge clk); #1;
        d_req_valid = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rst_mid.beat2_we", 32'(mem_we), 32'd1);
        chk("rst_mid.beat2_addr", mem_addr, 32'h302);
        reset = 1'b1;
        #1;
        chk("rst_mid.strobes", {30'd0, mem_re, mem_we}, 32'd0);
        @(negedge clk); #1;
        reset = 1'b0;
        quiet = 0;
        repeat (6) begin
            if (d_rsp_valid || i_rsp_valid || mem_we || mem_re) quiet++;
            @(negedge clk); #1;
        end
        chk("rst_mid.no_rsp", 32'(quiet), 32'd0);
        chk("rst_mid.mem", {mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]}, 32'hDDCC_2211);
        ref_mem[12'h300] = 8'h11; ref_mem[12'h301] = 8'h22;
        do_req("rst_mid.after", 1'b1, 1'b0, 2'd2, 32'h300, 32'h0, 32'hDDCC_2211);

        // Directed vectors.
        for (int v = 0; v < 11; v++)
            do_req($sformatf("vec%0d", v), vt[v].is_d, vt[v].we, vt[v].size,
                   vt[v].addr, vt[v].wdata, vt[v].exp);
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];

        // Randomized traffic against the reference model.
        for (int r = 0; r < 40; r++) begin
            rd  = 1'($urandom_range(0, 1));
            rw  = rd ? 1'($urandom_range(0, 1)) : 1'b0;
            rs  = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                              : 32'h400 + 32'($urandom_range(0, 63));
            rwd = $urandom;
            model_access(rd, rw, rs, ra, rwd, exp_r);
            do_req($sformatf("rnd%0d", r), rd, rw, rs, ra, rwd, exp_r);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
